// File: rtl/arbitro_pkg.sv
// Shared definitions for the multiplier arbiter: FSM states, datapath widths
// and the round-robin winner search.
package arbitro_pkg;

   localparam int OP_W   = 32;
   localparam int PROD_W = 64;
   localparam int MAX_CH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // First asserted request at or above ptr, wrapping at n; lowest offset wins.
   function automatic int rr_winner(input logic [MAX_CH-1:0] req, input int ptr, input int n);
      int idx;
      rr_winner = 0;
      for (int k = MAX_CH - 1; k >= 0; k--) begin
         if (k < n) begin
            idx = (ptr + k) % n;
            if (req[idx[2:0]]) rr_winner = idx;
         end
      end
   endfunction

endpackage

// File: rtl/cola_tags.sv
// In-order tag FIFO holding the channel of every multiply still in flight.
module cola_tags #(
   parameter int TAG_DEPTH = 4,
   parameter int CH_W      = 1,
   localparam int CW       = $clog2(TAG_DEPTH + 1)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            push,
   input  logic [CH_W-1:0] push_data,
   input  logic            pop,
   output logic [CH_W-1:0] pop_data,
   output logic            full,
   output logic            empty,
   output logic [CW-1:0]   count
);

   localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

   logic [CH_W-1:0] r_mem [TAG_DEPTH];
   logic [PW-1:0]   r_wr;
   logic [PW-1:0]   r_rd;
   logic [CW-1:0]   r_count;
   logic            w_doPush;
   logic            w_doPop;

   assign full     = (r_count == CW'(TAG_DEPTH));
   assign empty    = (r_count == '0);
   assign count    = r_count;
   assign pop_data = r_mem[r_rd];
   assign w_doPush = push && !full;
   assign w_doPop  = pop && !empty;

   always_ff @(posedge clock) begin
      if (w_doPush) r_mem[r_wr] <= push_data;
   end

   // Pointers wrap explicitly so non-power-of-two depths work.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) r_wr <= (r_wr == PW'(TAG_DEPTH - 1)) ? '0 : r_wr + PW'(1);
         if (w_doPop)  r_rd <= (r_rd == PW'(TAG_DEPTH - 1)) ? '0 : r_rd + PW'(1);
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/arbitro_multiplicador.sv
// Shares one pipelined 32x32 signed multiplier among NUM_CH requesters and
// returns tagged products in issue order. ARB_FIXED_PRIO_EN selects fixed priority.
module arbitro_multiplicador
   import arbitro_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int CH_W      = 1,
   parameter int TAG_DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [NUM_CH-1:0]      req_valid,
   input  logic [NUM_CH*32-1:0]   req_a,
   input  logic [NUM_CH*32-1:0]   req_b,
   output logic [NUM_CH-1:0]      req_ready,
   output logic [31:0]            mul_a,
   output logic [31:0]            mul_b,
   output logic                   mul_valid,
   input  logic [63:0]            mul_result,
   input  logic                   mul_result_valid,
   output logic [63:0]            res_data,
   output logic [CH_W-1:0]        res_ch,
   output logic                   res_valid,
   output logic                   busy,
   output logic                   err_underflow
);

   localparam int CW = $clog2(TAG_DEPTH + 1);

   state_t              r_state;
   logic [OP_W-1:0]     r_mulA;
   logic [OP_W-1:0]     r_mulB;
   logic                r_mulValid;
   logic [PROD_W-1:0]   r_resData;
   logic [CH_W-1:0]     r_resCh;
   logic                r_resValid;
   logic                r_errUnderflow;
   logic [CH_W-1:0]     w_win;
   logic [CH_W-1:0]     w_head;
   logic                w_full;
   logic                w_empty;
   logic [CW-1:0]       w_count;
   logic                w_grantOk;
   logic                w_pop;
   logic [OP_W-1:0]     w_opA;
   logic [OP_W-1:0]     w_opB;
   logic [NUM_CH-1:0]   w_ready;

`ifdef ARB_FIXED_PRIO_EN
   assign w_win = CH_W'(rr_winner(MAX_CH'(req_valid), 0, NUM_CH));
`else
   logic [CH_W-1:0] r_ptr;

   assign w_win = CH_W'(rr_winner(MAX_CH'(req_valid), int'(r_ptr), NUM_CH));

   always_ff @(posedge clock or posedge reset) begin
      if (reset)          r_ptr <= '0;
      else if (w_grantOk) r_ptr <= (w_win == CH_W'(NUM_CH - 1)) ? '0 : w_win + CH_W'(1);
   end
`endif

   // Fullness uses the pre-pop count, so a same-cycle pop never frees a slot.
   assign w_grantOk = (r_state == ST_RUN) && !w_full && (|req_valid);
   assign w_pop     = mul_result_valid && !w_empty;

   always_comb begin
      w_ready = '0;
      w_opA   = '0;
      w_opB   = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (w_win == CH_W'(k)) begin
            w_ready[k] = w_grantOk;
            w_opA      = req_a[k*OP_W +: OP_W];
            w_opB      = req_b[k*OP_W +: OP_W];
         end
      end
   end

   cola_tags #(
      .TAG_DEPTH (TAG_DEPTH),
      .CH_W      (CH_W)
   ) u_colaTags (
      .clock     (clock),
      .reset     (reset),
      .push      (w_grantOk),
      .push_data (w_win),
      .pop       (w_pop),
      .pop_data  (w_head),
      .full      (w_full),
      .empty     (w_empty),
      .count     (w_count)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  if (enable) r_state <= ST_RUN;
            ST_RUN:   if (!enable) r_state <= ST_DRAIN;
            ST_DRAIN: if ((w_count == '0) && !r_mulValid) r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_mulA     <= '0;
         r_mulB     <= '0;
         r_mulValid <= 1'b0;
      end else begin
         r_mulValid <= w_grantOk;
         if (w_grantOk) begin
            r_mulA <= w_opA;
            r_mulB <= w_opB;
         end
      end
   end

   // A product with no tag to pair it with is dropped and latched as an error.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_resData      <= '0;
         r_resCh        <= '0;
         r_resValid     <= 1'b0;
         r_errUnderflow <= 1'b0;
      end else begin
         r_resValid <= w_pop;
         if (w_pop) begin
            r_resData <= mul_result;
            r_resCh   <= w_head;
         end
         if (mul_result_valid && w_empty) r_errUnderflow <= 1'b1;
      end
   end

   assign req_ready     = w_ready;
   assign mul_a         = r_mulA;
   assign mul_b         = r_mulB;
   assign mul_valid     = r_mulValid;
   assign res_data      = r_resData;
   assign res_ch        = r_resCh;
   assign res_valid     = r_resValid;
   assign busy          = (r_state != ST_IDLE);
   assign err_underflow = r_errUnderflow;

endmodule

// File: tb/tb_arbitro_multiplicador.sv
// Self-checking bench: pipelined multiplier model plus a cycle-level reference
// of arbitration, tag ordering, draining and underflow behaviour.
module tb_arbitro_multiplicador;

   localparam int NUM_CH    = 2;
   localparam int CH_W      = 1;
   localparam int TAG_DEPTH = 4;

   logic                  clock;
   logic                  reset;
   logic                  enable;
   logic [NUM_CH-1:0]     req_valid;
   logic [NUM_CH*32-1:0]  req_a;
   logic [NUM_CH*32-1:0]  req_b;
   logic [NUM_CH-1:0]     req_ready;
   logic [31:0]           mul_a;
   logic [31:0]           mul_b;
   logic                  mul_valid;
   logic [63:0]           mul_result;
   logic                  mul_result_valid;
   logic [63:0]           res_data;
   logic [CH_W-1:0]       res_ch;
   logic                  res_valid;
   logic                  busy;
   logic                  err_underflow;

   int assertCount = 0;
   int failCount   = 0;

   arbitro_multiplicador #(
      .NUM_CH    (NUM_CH),
      .CH_W      (CH_W),
      .TAG_DEPTH (TAG_DEPTH)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .enable           (enable),
      .req_valid        (req_valid),
      .req_a            (req_a),
      .req_b            (req_b),
      .req_ready        (req_ready),
      .mul_a            (mul_a),
      .mul_b            (mul_b),
      .mul_valid        (mul_valid),
      .mul_result       (mul_result),
      .mul_result_valid (mul_result_valid),
      .res_data         (res_data),
      .res_ch           (res_ch),
      .res_valid        (res_valid),
      .busy             (busy),
      .err_underflow    (err_underflow)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // External multiplier model: fixed-latency pipeline cleared with the arbiter.
   logic        pipeV [16];
   logic [63:0] pipeD [16];
   logic [3:0]  latSel;
   logic        forcePulse;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) pipeV[i] <= 1'b0;
      end else begin
         pipeV[0] <= mul_valid;
         pipeD[0] <= 64'(longint'($signed(mul_a)) * longint'($signed(mul_b)));
         for (int i = 1; i < 16; i++) begin
            pipeV[i] <= pipeV[i-1];
            pipeD[i] <= pipeD[i-1];
         end
      end
   end

   assign mul_result_valid = pipeV[latSel] | forcePulse;
   assign mul_result       = pipeD[latSel];

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: operating mode flags and a scoreboard of issued operations.
   typedef struct {
      int     ch;
      longint prod;
   } entry_t;

   entry_t      sb[$];
   bit          running;
   bit          draining;
   int          rrPtr;
   bit          expMulValid;
   logic [31:0] expMulA;
   logic [31:0] expMulB;
   bit          expResValid;
   logic [63:0] expResData;
   int          expResCh;
   bit          expErr;

   always @(negedge clock) begin
      int     win;
      int     sizeBefore;
      bit     mvBefore;
      bit     canGrant;
      logic [NUM_CH-1:0] expReady;
      entry_t e;

      if (reset) begin
         sb.delete();
         running     = 1'b0;
         draining    = 1'b0;
         rrPtr       = 0;
         expMulValid = 1'b0;
         expMulA     = '0;
         expMulB     = '0;
         expResValid = 1'b0;
         expResData  = '0;
         expResCh    = 0;
         expErr      = 1'b0;
      end

      win = -1;
      for (int k = 0; k < NUM_CH; k++) begin
         int c;
         c = (rrPtr + k) % NUM_CH;
         if (req_valid[c] && win < 0) win = c;
      end
      canGrant = running && (sb.size() < TAG_DEPTH) && (win >= 0);
      expReady = canGrant ? NUM_CH'(1 << win) : '0;

      checkOutput("req_ready", 64'(req_ready), 64'(expReady));
      checkOutput("mul_valid", 64'(mul_valid), 64'(expMulValid));
      checkOutput("mul_a", 64'(mul_a), 64'(expMulA));
      checkOutput("mul_b", 64'(mul_b), 64'(expMulB));
      checkOutput("res_valid", 64'(res_valid), 64'(expResValid));
      checkOutput("res_data", res_data, expResData);
      checkOutput("res_ch", 64'(res_ch), 64'(expResCh));
      checkOutput("busy", 64'(busy), 64'(running || draining));
      checkOutput("err_underflow", 64'(err_underflow), 64'(expErr));

      if (!reset) begin
         sizeBefore = sb.size();
         mvBefore   = expMulValid;

         expResValid = 1'b0;
         if (mul_result_valid) begin
            if (sizeBefore > 0) begin
               e           = sb.pop_front();
               expResValid = 1'b1;
               expResData  = 64'(e.prod);
               expResCh    = e.ch;
            end else begin
               expErr = 1'b1;
            end
         end

         expMulValid = canGrant;
         if (canGrant) begin
            e.ch    = win;
            e.prod  = longint'($signed(req_a[win*32 +: 32])) * longint'($signed(req_b[win*32 +: 32]));
            sb.push_back(e);
            expMulA = req_a[win*32 +: 32];
            expMulB = req_b[win*32 +: 32];
`ifndef ARB_FIXED_PRIO_EN
            rrPtr = (win + 1) % NUM_CH;
`endif
         end

         if (running) begin
            if (!enable) begin
               running  = 1'b0;
               draining = 1'b1;
            end
         end else if (draining) begin
            if (sizeBefore == 0 && !mvBefore) draining = 1'b0;
         end else if (enable) begin
            running = 1'b1;
         end
      end
   end

   task automatic doReset(input int lat);
      @(posedge clock);
      #1;
      reset      = 1'b1;
      enable     = 1'b0;
      req_valid  = '0;
      forcePulse = 1'b0;
      latSel     = 4'(lat - 1);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic applyStimulus(input logic en, input logic [NUM_CH-1:0] v,
                                input logic [NUM_CH*32-1:0] a, input logic [NUM_CH*32-1:0] b,
                                input int cycles);
      enable    = en;
      req_valid = v;
      req_a     = a;
      req_b     = b;
      repeat (cycles) @(posedge clock);
      #1;
   endtask

   initial begin
      logic [NUM_CH*32-1:0] ra;
      logic [NUM_CH*32-1:0] rb;
      reset      = 1'b1;
      enable     = 1'b0;
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      forcePulse = 1'b0;
      latSel     = 4'd1;

      // Alternating I/Q style traffic, latency 2.
      doReset(2);
      applyStimulus(1'b1, 2'b11, {32'd7, 32'd3}, {32'd2, 32'hFFFF_FFFB}, 20);

      // Single channel at the largest positive operands.
      doReset(2);
      applyStimulus(1'b1, 2'b10, {32'h7FFF_FFFF, 32'd0}, {32'h7FFF_FFFF, 32'd0}, 15);

      // Slow multiplier: tag queue fills and throttles grants.
      doReset(10);
      applyStimulus(1'b1, 2'b11, {32'd11, 32'hFFFF_FFFF}, {32'd13, 32'd17}, 40);

      // Drop enable with three operations in flight.
      doReset(10);
      applyStimulus(1'b1, 2'b11, {32'd5, 32'd6}, {32'd9, 32'd4}, 4);
      applyStimulus(1'b0, 2'b11, {32'd5, 32'd6}, {32'd9, 32'd4}, 20);

      // Product with nothing in flight latches the error; reset clears it.
      doReset(2);
      forcePulse = 1'b1;
      applyStimulus(1'b0, 2'b00, '0, '0, 1);
      forcePulse = 1'b0;
      applyStimulus(1'b0, 2'b00, '0, '0, 6);
      checkOutput("err_sticky", 64'(err_underflow), 64'd1);
      doReset(2);
      checkOutput("err_cleared", 64'(err_underflow), 64'd0);

      // Randomized traffic, latencies and enable toggling.
      for (int seg = 0; seg < 8; seg++) begin
         doReset(int'($urandom_range(1, 8)));
         for (int cyc = 0; cyc < 80; cyc++) begin
            for (int k = 0; k < NUM_CH; k++) begin
               ra[k*32 +: 32] = $urandom;
               rb[k*32 +: 32] = $urandom;
            end
            applyStimulus(($urandom_range(0, 9) != 0), NUM_CH'($urandom), ra, rb, 1);
            if (seg == 5 && cyc == 40) doReset(3);
         end
      end

      applyStimulus(1'b0, '0, '0, '0, 30);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/arbitro_multiplicador.md
Name: arbitro_multiplicador

Overview:
Shares one external pipelined signed 32x32 multiplier between NUM_CH streaming requesters (e.g. I and Q reference mixers of the lock-in).
- Arbitrates requests round-robin and drives the multiplier operand bus.
- Tracks in-flight channel tags in an in-order tag queue.
- Returns each 64-bit product tagged with its originating channel.
- Sits between the reference/sample front end and the per-channel low-pass filters.

Parameters:
- NUM_CH, 2, number of requesters (2..8).
- CH_W, 1, tag width; must be >= clog2(NUM_CH).
- TAG_DEPTH, 4, tag queue depth; must be >= multiplier latency + 1.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  permits issuing new operations.
- req_valid  in  NUM_CH  per-channel request valid.
- req_a  in  NUM_CH*32  signed operand A, channel k at bits [32k+31:32k].
- req_b  in  NUM_CH*32  signed operand B, same packing.
- req_ready  out  NUM_CH  one-hot grant, combinational.
- mul_a  out  32  registered operand A to multiplier.
- mul_b  out  32  registered operand B to multiplier.
- mul_valid  out  1  registered operand valid.
- mul_result  in  64  signed product from multiplier.
- mul_result_valid  in  1  product valid.
- res_data  out  64  registered product.
- res_ch  out  CH_W  channel tag of res_data.
- res_valid  out  1  one-cycle pulse per result.
- busy  out  1  high when state != IDLE.
- err_underflow  out  1  sticky error flag.

Behaviour:
Reset values: mul_a=0, mul_b=0, mul_valid=0, res_data=0, res_ch=0, res_valid=0, err_underflow=0, rr pointer=0, tag queue empty, state=IDLE.

FSM states:
- IDLE: enable=1 -> RUN.
- RUN: enable=0 -> DRAIN.
- DRAIN: tag queue empty and mul_valid=0 -> IDLE.
- DRAIN never returns directly to RUN. Re-asserting enable during DRAIN takes effect one cycle after reaching IDLE.

Grant:
- A grant is possible only when state=RUN, the queue is not full, and |req_valid.
- Selection is round-robin: first asserted channel searched from rr pointer upward, wrapping at NUM_CH.
- req_ready is one-hot for the granted channel, else all zero. A transfer is req_valid&req_ready.
- On a grant, the rr pointer moves to granted+1 (mod NUM_CH). It is unchanged when there is no grant.

Issue:
- Grant in cycle t -> mul_a/mul_b/mul_valid valid at t+1.
- mul_valid=0 in every cycle without a grant; mul_a/mul_b hold their values.
- The granted channel index is pushed into the tag queue in cycle t.

Completion:
- mul_result_valid in cycle u pops the queue head.
- res_data=mul_result, res_ch=head, res_valid=1 at u+1.
- res_valid is 0 otherwise; res_data/res_ch hold.
- Results are strictly in issue order. No backpressure on res_*.

Queue boundaries:
- Full means TAG_DEPTH entries. A full queue blocks grants even if a pop occurs in the same cycle (push is checked against the pre-pop count).
- Simultaneous push and pop when not full: count unchanged.
- mul_result_valid with an empty queue: no pop, res_valid=0, err_underflow set until reset.

Reset mid-operation:
- Asynchronous reset clears all state, including in-flight tags.
- Products arriving later flag err_underflow; the integrator avoids this by resetting the multiplier together with this block.

Width: operands pass through unmodified; no arithmetic in this block.

Optional Feature:
- ARB_FIXED_PRIO_EN defined: fixed priority, lowest asserted channel index wins; rr pointer removed.
- Undefined (default): round-robin as above.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package arbitro_pkg holds: state enum (IDLE/RUN/DRAIN), operand width constant 32, product width constant 64, and a function returning the round-robin winner index.
- One natural sub-module: cola_tags, a synchronous in-order FIFO with parameters TAG_DEPTH and CH_W. Ports: push, push_data, pop, pop_data, full, empty, count.

Test Plan:
1. Reset, then enable=1, NUM_CH=2, both req_valid=1 continuously, ch0 a=3 b=-5, ch1 a=7 b=2, multiplier model latency 2 -> grants alternate ch0,ch1,ch0…; res sequence -15(ch0), 14(ch1), repeating. res_valid first at cycle 4 after first grant.
2. Only ch1 requesting, a=0x7FFFFFFF b=0x7FFFFFFF -> every grant goes to ch1; res_data=0x3FFFFFFF00000001, res_ch=1.
3. Multiplier model stalls results (latency 10), TAG_DEPTH=4 -> exactly 4 grants, then req_ready=0 until the first pop. No grant in the pop cycle; a grant is possible the cycle after.
4. enable dropped with 3 ops in flight -> state DRAIN, no new grants, 3 results delivered, busy falls the cycle after the queue empties, state IDLE.
5. mul_result_valid pulsed with empty queue -> err_underflow=1 and stays 1; res_valid stays 0; reset clears it.
6. Build with ARB_FIXED_PRIO_EN, both channels requesting -> only ch0 granted while ch0 req_valid=1.
